// File: rtl/sme_feeder.sv
// sme_feeder: streams the preloaded string/pattern buffers to the matching engine and captures its result; start-to-first-char 1 cycle, valid-to-done 1 cycle.
// No backpressure: the engine takes one char per cycle. Optional WAIT timeout is enabled by defining SME_FEEDER_TIMEOUT_EN.
module sme_feeder #(
    parameter int STR_DEPTH      = 32,
    parameter int PAT_DEPTH      = 10,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [5:0] str_len,
    input  logic [3:0] pat_len,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       timeout,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index
);

    typedef enum logic [2:0] {IDLE, SEND_S, SEND_P, WAIT, FIN} state_t;

    localparam logic [5:0] STR_MAX = 6'(STR_DEPTH);
    localparam logic [3:0] PAT_MAX = 4'(PAT_DEPTH);

    if (STR_DEPTH < 1 || STR_DEPTH > 32 || PAT_DEPTH < 1 || PAT_DEPTH > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 4096) begin : g_bad_cfg
        $error("sme_feeder: parameter out of range");
    end

    state_t     r_state;
    logic [7:0] r_sbuf [STR_DEPTH];
    logic [7:0] r_pbuf [PAT_DEPTH];
    logic [4:0] r_sidx;
    logic [4:0] r_slast;
    logic [3:0] r_pidx;
    logic [3:0] r_plast;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic       r_res_match;
    logic [4:0] r_res_index;
    logic [7:0] r_chardata;
    logic       r_isstring;
    logic       r_ispattern;

    logic       w_start_bad;
    logic [4:0] w_sidx_nxt;
    logic [3:0] w_pidx_nxt;

    assign w_start_bad = (pat_len == 4'd0) || (pat_len > PAT_MAX) || (str_len > STR_MAX);
    assign w_sidx_nxt  = r_sidx + 5'd1;
    assign w_pidx_nxt  = r_pidx + 4'd1;

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign res_match = r_res_match;
    assign res_index = r_res_index;
    assign chardata  = r_chardata;
    assign isstring  = r_isstring;
    assign ispattern = r_ispattern;

`ifdef SME_FEEDER_TIMEOUT_EN
    localparam logic [11:0] T_LAST = 12'(TIMEOUT_CYCLES - 1);
    logic [11:0] r_tcnt;
    logic        r_timeout;
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    // Buffers are only writable while idle and are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && r_state == IDLE) begin
            if (!wr_sel && {1'b0, wr_addr} < STR_MAX)
                r_sbuf[wr_addr] <= wr_data;
            if (wr_sel && {1'b0, wr_addr} < {2'b00, PAT_MAX})
                r_pbuf[wr_addr[3:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sidx      <= '0;
            r_slast     <= '0;
            r_pidx      <= '0;
            r_plast     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_res_match <= 1'b0;
            r_res_index <= '0;
            r_chardata  <= '0;
            r_isstring  <= 1'b0;
            r_ispattern <= 1'b0;
`ifdef SME_FEEDER_TIMEOUT_EN
            r_tcnt      <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_start_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_slast     <= 5'(str_len - 6'd1);
                            r_plast     <= pat_len - 4'd1;
                            r_sidx      <= '0;
                            r_pidx      <= '0;
                            r_res_match <= 1'b0;
                            r_res_index <= '0;
                            r_busy      <= 1'b1;
`ifdef SME_FEEDER_TIMEOUT_EN
                            r_timeout   <= 1'b0;
`endif
                            if (str_len != 6'd0) begin
                                r_state    <= SEND_S;
                                r_chardata <= r_sbuf[0];
                                r_isstring <= 1'b1;
                            end else begin
                                r_state     <= SEND_P;
                                r_chardata  <= r_pbuf[0];
                                r_ispattern <= 1'b1;
                            end
                        end
                    end
                end
                SEND_S: begin
                    // Last string char hands straight over to pattern char 0 with no gap.
                    if (r_sidx == r_slast) begin
                        r_state     <= SEND_P;
                        r_pidx      <= '0;
                        r_chardata  <= r_pbuf[0];
                        r_isstring  <= 1'b0;
                        r_ispattern <= 1'b1;
                    end else begin
                        r_sidx     <= w_sidx_nxt;
                        r_chardata <= r_sbuf[w_sidx_nxt];
                    end
                end
                SEND_P: begin
                    if (r_pidx == r_plast) begin
                        r_state     <= WAIT;
                        r_chardata  <= '0;
                        r_ispattern <= 1'b0;
`ifdef SME_FEEDER_TIMEOUT_EN
                        r_tcnt      <= '0;
`endif
                    end else begin
                        r_pidx     <= w_pidx_nxt;
                        r_chardata <= r_pbuf[w_pidx_nxt];
                    end
                end
                WAIT: begin
                    // A valid on the expiry edge takes priority over the timeout.
                    if (valid) begin
                        r_res_match <= match;
                        r_res_index <= match_index;
                        r_done      <= 1'b1;
                        r_state     <= FIN;
                    end
`ifdef SME_FEEDER_TIMEOUT_EN
                    else if (r_tcnt == T_LAST) begin
                        r_timeout   <= 1'b1;
                        r_res_match <= 1'b0;
                        r_res_index <= '0;
                        r_done      <= 1'b1;
                        r_state     <= FIN;
                    end else begin
                        r_tcnt <= r_tcnt + 12'd1;
                    end
`endif
                end
                FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sme_feeder.sv
// Randomised bench for sme_feeder: frames are predicted from a model of the buffers and compared cycle by cycle.
module tb_sme_feeder;

    logic       clk = 1'b0;
    logic       reset, wr_en, wr_sel, start, valid, match;
    logic [4:0] wr_addr, match_index;
    logic [7:0] wr_data;
    logic [5:0] str_len;
    logic [3:0] pat_len;
    logic       busy, done, err, res_match, timeout, isstring, ispattern;
    logic [4:0] res_index;
    logic [7:0] chardata;

    int         nvec = 0;
    int         nerr = 0;
    logic [7:0] m_s [32];
    logic [7:0] m_p [10];

    sme_feeder #(.STR_DEPTH(32), .PAT_DEPTH(10), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .str_len(str_len), .pat_len(pat_len), .start(start),
        .busy(busy), .done(done), .err(err), .res_match(res_match), .res_index(res_index),
        .timeout(timeout), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .valid(valid), .match(match), .match_index(match_index)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel, input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        if (!sel) m_s[a] = d;
        else if (a < 5'd10) m_p[a[3:0]] = d;
    endtask

    task automatic load_str(input string s, input bit sel);
        for (int i = 0; i < s.len(); i++) wr(sel, 5'(i), s[i]);
    endtask

    // One full transaction: expected frame built from the buffer model, engine answers after vdly WAIT cycles.
    task automatic run_txn(input int slen, input int plen, input int vdly, input bit vm,
                           input logic [4:0] vi, input bit inj, input bit noise);
        logic [9:0] exp_q[$];
        for (int i = 0; i < slen; i++) exp_q.push_back({2'b10, m_s[i]});
        for (int i = 0; i < plen; i++) exp_q.push_back({2'b01, m_p[i]});
        str_len = 6'(slen); pat_len = 4'(plen); start = 1'b1;
        tick();
        start = 1'b0;
        nvec++;
        if (busy !== 1'b1 || res_match !== 1'b0 || res_index !== 5'd0 || timeout !== 1'b0) begin
            nerr++;
            $display("FAIL txn_start: busy=%b res=%b/%0d to=%b, expected busy=1 res=0/0 to=0",
                     busy, res_match, res_index, timeout);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            nvec++;
            if ({isstring, ispattern, chardata} !== exp_q[i]) begin
                nerr++;
                $display("FAIL frame[%0d] len=%0d/%0d: got %h expected %h", i, slen, plen,
                         {isstring, ispattern, chardata}, exp_q[i]);
            end
            if (inj && i == 0) begin
                valid = 1'b1; match = 1'b1; match_index = 5'd31;
            end
            if (noise) begin
                wr_en = 1'b1; wr_sel = 1'($urandom); wr_addr = 5'($urandom_range(0, 9));
                wr_data = 8'($urandom); start = 1'($urandom);
            end
            tick();
            valid = 1'b0; wr_en = 1'b0; start = 1'b0;
        end
        nvec++;
        if ({isstring, ispattern, chardata} !== 10'd0 || busy !== 1'b1 || done !== 1'b0) begin
            nerr++;
            $display("FAIL wait_idle_bus: bus=%h busy=%b done=%b, expected bus=0 busy=1 done=0",
                     {isstring, ispattern, chardata}, busy, done);
        end
        repeat (vdly) tick();
        nvec++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL wait_hold: done=%b busy=%b, expected done=0 busy=1", done, busy);
        end
        valid = 1'b1; match = vm; match_index = vi;
        tick();
        valid = 1'b0; match = 1'($urandom); match_index = 5'($urandom);
        nvec++;
        if (done !== 1'b1 || busy !== 1'b1 || res_match !== vm || res_index !== vi || timeout !== 1'b0) begin
            nerr++;
            $display("FAIL result: done=%b busy=%b res=%b/%0d to=%b, expected 1 1 %b/%0d 0",
                     done, busy, res_match, res_index, timeout, vm, vi);
        end
        tick();
        nvec++;
        if (done !== 1'b0 || busy !== 1'b0 || res_match !== vm || res_index !== vi) begin
            nerr++;
            $display("FAIL after_fin: done=%b busy=%b res=%b/%0d, expected 0 0 %b/%0d",
                     done, busy, res_match, res_index, vm, vi);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        nvec++;
        if ({busy, done, err, res_match, res_index, timeout, chardata, isstring, ispattern} !== 20'd0) begin
            nerr++;
            $display("FAIL reset_state: got %h expected 0",
                     {busy, done, err, res_match, res_index, timeout, chardata, isstring, ispattern});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        load_str("abcde", 1'b0);
        load_str("cd", 1'b1);
        run_txn(5, 2, 2, 1'b1, 5'd2, 1'b0, 1'b0);
        load_str("^ab", 1'b1);
        run_txn(0, 3, 0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_err();
        logic [5:0] sl [3] = '{6'd3, 6'd33, 6'd4};
        logic [3:0] pl [3] = '{4'd11, 4'd2, 4'd0};
        for (int k = 0; k < 3; k++) begin
            str_len = sl[k]; pat_len = pl[k]; start = 1'b1;
            tick();
            start = 1'b0;
            nvec++;
            if (err !== 1'b1 || busy !== 1'b0 || isstring !== 1'b0 || ispattern !== 1'b0) begin
                nerr++;
                $display("FAIL err_pulse[%0d]: err=%b busy=%b qual=%b%b, expected 1 0 00",
                         k, err, busy, isstring, ispattern);
            end
            tick();
            nvec++;
            if (err !== 1'b0 || busy !== 1'b0 || isstring !== 1'b0 || ispattern !== 1'b0) begin
                nerr++;
                $display("FAIL err_clear[%0d]: err=%b busy=%b qual=%b%b, expected 0 0 00",
                         k, err, busy, isstring, ispattern);
            end
        end
    endtask

    task automatic test_early_valid();
        load_str("xyzzy", 1'b0);
        run_txn(5, 2, 1, 1'b1, 5'd7, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        load_str("hello", 1'b0);
        load_str("lo", 1'b1);
        str_len = 6'd5; pat_len = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nvec++;
        if (isstring !== 1'b0 || ispattern !== 1'b0 || chardata !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid: qual=%b%b char=%h busy=%b done=%b, expected all 0",
                     isstring, ispattern, chardata, busy, done);
        end
        tick();
        run_txn(5, 2, 0, 1'b1, 5'd3, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 14; t++) begin
            int slen, plen;
            repeat ($urandom_range(0, 5)) wr(1'($urandom), 5'($urandom), 8'($urandom));
            slen = (t == 0) ? 32 : $urandom_range(0, 32);
            plen = (t == 0) ? 10 : $urandom_range(1, 10);
            run_txn(slen, plen, $urandom_range(0, 5), 1'($urandom), 5'($urandom),
                    (slen > 0) && 1'($urandom), 1'b1);
        end
    endtask

`ifdef SME_FEEDER_TIMEOUT_EN
    task automatic test_timeout();
        for (int k = 0; k < 2; k++) begin
            str_len = 6'd2; pat_len = 4'd1; start = 1'b1;
            tick();
            start = 1'b0;
            repeat (3) tick();
            repeat (15) tick();
            nvec++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                nerr++;
                $display("FAIL timeout_early[%0d]: done=%b busy=%b, expected 0 1", k, done, busy);
            end
            if (k == 1) begin
                valid = 1'b1; match = 1'b1; match_index = 5'd9;
            end
            tick();
            valid = 1'b0;
            nvec++;
            if (k == 0 && (done !== 1'b1 || timeout !== 1'b1 || res_match !== 1'b0 || res_index !== 5'd0)) begin
                nerr++;
                $display("FAIL timeout_fire: done=%b to=%b res=%b/%0d, expected 1 1 0/0",
                         done, timeout, res_match, res_index);
            end
            if (k == 1 && (done !== 1'b1 || timeout !== 1'b0 || res_match !== 1'b1 || res_index !== 5'd9)) begin
                nerr++;
                $display("FAIL timeout_race: done=%b to=%b res=%b/%0d, expected 1 0 1/9",
                         done, timeout, res_match, res_index);
            end
            tick();
        end
    endtask
`else
    task automatic test_no_timeout();
        str_len = 6'd1; pat_len = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (60) tick();
        nvec++;
        if (busy !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) begin
            nerr++;
            $display("FAIL wait_forever: busy=%b done=%b to=%b, expected 1 0 0", busy, done, timeout);
        end
        valid = 1'b1; match = 1'b0; match_index = 5'd4;
        tick();
        valid = 1'b0;
        tick();
    endtask
`endif

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        str_len = '0; pat_len = '0; start = 1'b0; valid = 1'b0; match = 1'b0; match_index = '0;
        test_reset();
        for (int i = 0; i < 32; i++) wr(1'b0, 5'(i), 8'($urandom));
        for (int i = 0; i < 32; i++) wr(1'b1, 5'(i), 8'($urandom));
        test_basic();
        test_err();
        test_early_valid();
        test_reset_mid();
        test_random();
`ifdef SME_FEEDER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
